reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port clb  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have port load_reg  input  1  meaning write enable.
REQ-006 SHALL have port wr_addr  input  ADDR_W  meaning write address.
REQ-007 SHALL have port wr_data  input  DATA_W  meaning write data (from accumulator).
REQ-008 SHALL have port clr_req  input  1  meaning request to zero all registers.
REQ-009 SHALL have port rd_addr_a  input  ADDR_W  meaning read port A address.
REQ-010 SHALL have port rd_data_a  output  DATA_W  meaning read port A data, registered.
REQ-011 SHALL have port rd_addr_b  input  ADDR_W  meaning read port B address.
REQ-012 SHALL have port rd_data_b  output  DATA_W  meaning read port B data, registered.
REQ-013 SHALL have port busy  output  1  meaning clear sequence in progress.

Function
REQ-014 SHALL implement FSM states CLEAR and IDLE, plus clear counter clr_cnt of ADDR_W bits.
REQ-015 In CLEAR, SHALL write 0 to register clr_cnt each cycle and increment clr_cnt; busy=1.
REQ-016 SHALL transition CLEAR->IDLE on the cycle clr_cnt==DEPTH-1 is written, with clr_cnt wrapping to 0; a full clear takes exactly DEPTH cycles.
REQ-017 In IDLE, SHALL write wr_data to register wr_addr when load_reg=1; busy=0.
REQ-018 In IDLE, clr_req=1 SHALL transition to CLEAR next cycle with clr_cnt=0; a simultaneous load_reg write in that cycle SHALL still be performed.
REQ-019 In CLEAR, load_reg and clr_req SHALL be ignored; clear is not restarted.
REQ-020 Read ports SHALL have 1-cycle latency: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
REQ-021 Read ports SHALL be independent; rd_addr_a==rd_addr_b SHALL return identical data.
REQ-022 While busy=1, rd_data_a and rd_data_b SHALL be loaded with 0.
REQ-023 Read of an address being written in the same cycle SHALL follow REQ-034/REQ-035.

Reset
REQ-024 Asserting clb SHALL immediately force state=CLEAR, clr_cnt=0, busy=1, rd_data_a=0, rd_data_b=0.
REQ-025 Register array SHALL NOT be reset directly; zeroing is done by the CLEAR sequence after clb deasserts.
REQ-026 Reset asserted mid-clear or mid-write SHALL abort the operation and restart CLEAR from address 0.
REQ-027 First register write after clb deassertion SHALL be address 0 on the first rising edge.

Configuration
REQ-028 Macro REG_BANK_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REG_BANK_BYPASS_EN defined, if IDLE, load_reg=1 and rd_addr_x==wr_addr in the same cycle, rd_data_x next cycle SHALL equal wr_data.
REQ-030 Without REG_BANK_BYPASS_EN, in that case rd_data_x next cycle SHALL equal the register value before the write.
REQ-031 Both builds SHALL be otherwise cycle-identical.

Verification
REQ-032 Reset pulse, release -> busy=1 for exactly 16 cycles (defaults), then 0; reading all 16 addresses returns 0x00.
REQ-033 IDLE, write 0xA5 to addr 3, next cycle read A=3, B=3 -> both ports 0xA5 one cycle later.
REQ-034 Bypass build: load_reg=1, wr_addr=7, wr_data=0x3C, rd_addr_a=7 same cycle, old value 0x11 -> rd_data_a=0x3C next cycle.
REQ-035 Non-bypass build: same stimulus as REQ-034 -> rd_data_a=0x11 next cycle, 0x3C on a following read.
REQ-036 Write 0xFF to addr 15, clr_req=1; during busy load_reg=1 addr 2 0x55 -> after 16 cycles all addresses read 0x00, including 2 and 15.
REQ-037 Assert clb at clear cycle 5 -> busy stays 1, clear restarts at address 0, busy falls 16 cycles after release.

Source files
------------

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - dual-read-port register bank with self-clearing sequence
// Optional feature: define REG_BANK_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clb,
    input  logic              load_reg,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [DATA_W-1:0] w_nxt_a;
    logic [DATA_W-1:0] w_nxt_b;

    // Clear/idle sequencer; the clear walks every address once and the wrap of the counter ends it
    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    if (&r_clr_cnt) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Single write port: the clear sequence owns it while clearing, the accumulator otherwise
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = '0;
        end else begin
            w_we    = load_reg;
        end
    end

    // Storage array has no reset; the clear sequence is what zeroes it
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read data selection, with optional forwarding of a colliding idle write
    always_comb begin
        w_fwd_a = 1'b0;
        w_fwd_b = 1'b0;
`ifdef REG_BANK_BYPASS_EN
        w_fwd_a = (r_state == S_IDLE) && load_reg && (rd_addr_a == wr_addr);
        w_fwd_b = (r_state == S_IDLE) && load_reg && (rd_addr_b == wr_addr);
`else
        w_fwd_a = 1'b0;
        w_fwd_b = 1'b0;
`endif
        w_nxt_a = w_fwd_a ? wr_data : r_mem[rd_addr_a];
        w_nxt_b = w_fwd_b ? wr_data : r_mem[rd_addr_b];
    end

    // Registered read ports; forced to zero while the bank is being cleared
    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else if (r_state == S_CLEAR) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_a <= w_nxt_a;
            r_rd_b <= w_nxt_b;
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign busy      = r_busy;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clb;
    logic       load_reg;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_req;
    logic [3:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic [3:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       busy;

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .clb       (clb),
        .load_reg  (load_reg),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .busy      (busy)
    );

    typedef struct {
        logic       ld;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        string      name;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        load_reg = 1'b0;
        clr_req  = 1'b0;
    endtask

    // Drive one cycle; optionally queue the read result expected one edge later
    task automatic step(input logic ld, input logic [3:0] wa, input logic [7:0] wd, input logic cr,
                        input logic [3:0] ra, input logic [3:0] rb, input bit push,
                        input logic [7:0] ea, input logic [7:0] eb, input string name);
        exp_t e;
        load_reg  = ld;
        wr_addr   = wa;
        wr_data   = wd;
        clr_req   = cr;
        rd_addr_a = ra;
        rd_addr_b = rb;
        if (push) sb.push_back('{ea, eb, name});
        @(posedge clk);
        #1;
        if (push) begin
            if (sb.size() == 0) begin
                check({name, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check({e.name, "_a"}, {24'd0, rd_data_a}, {24'd0, e.a});
                check({e.name, "_b"}, {24'd0, rd_data_b}, {24'd0, e.b});
            end
        end
    endtask

    // Count edges until busy falls; read ports must stay zero throughout
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            check({name, "_rd_a_zero"}, {24'd0, rd_data_a}, 32'd0);
            check({name, "_rd_b_zero"}, {24'd0, rd_data_b}, 32'd0);
        end
        check({name, "_busy_cycles"}, n, 32'd16);
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'd0, 1'b0, 4'(i), 4'(15 - i), 1'b1, 8'h00, 8'h00, name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd0,  4'd1,  8'h00, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  4'd3,  8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 4'd7,  8'h11, 4'd3,  4'd0,  8'hA5, 8'h00};
        vecs[3] = '{1'b1, 4'd7,  8'h3C, 4'd7,  4'd3,  BYP ? 8'h3C : 8'h11, 8'hA5};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd7,  4'd7,  8'h3C, 8'h3C};
        vecs[5] = '{1'b1, 4'd15, 8'hFF, 4'd15, 4'd7,  BYP ? 8'hFF : 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 4'd0,  8'h5A, 4'd15, 4'd0,  8'hFF, BYP ? 8'h5A : 8'h00};
        vecs[7] = '{1'b1, 4'd8,  8'h81, 4'd0,  4'd8,  8'h5A, BYP ? 8'h81 : 8'h00};
        vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd8,  4'd15, 8'h81, 8'hFF};

        clb       = 1'b0;
        load_reg  = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 8'd0;
        clr_req   = 1'b0;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;

        // Asynchronous reset takes effect before any clock edge
        #2 clb = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd_a", {24'd0, rd_data_a}, 32'd0);
        check("reset_rd_b", {24'd0, rd_data_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clb = 1'b0;
        check("release_busy", {31'd0, busy}, 32'd1);
        wait_clear("por_clear");
        idle();
        read_all_zero("por_zero");

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].ld, vecs[i].wa, vecs[i].wd, 1'b0, vecs[i].ra, vecs[i].rb, 1'b1,
                 vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // Clear request with a simultaneous write, then writes and requests ignored while busy
        step(1'b1, 4'd15, 8'hFF, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, "clr_start");
        check("clr_req_busy", {31'd0, busy}, 32'd1);
        load_reg  = 1'b1;
        wr_addr   = 4'd2;
        wr_data   = 8'h55;
        clr_req   = 1'b1;
        rd_addr_a = 4'd2;
        rd_addr_b = 4'd15;
        wait_clear("clr_req_clear");
        idle();
        read_all_zero("clr_req_zero");

        // Reset in the middle of a clear restarts the full sequence
        step(1'b1, 4'd4, 8'h99, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, "rst_clr_start");
        idle();
        repeat (5) @(posedge clk);
        #1;
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        clb = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_rd_a", {24'd0, rd_data_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clb = 1'b0;
        check("mid_release_busy", {31'd0, busy}, 32'd1);
        wait_clear("rst_mid_clear");
        idle();
        read_all_zero("rst_mid_zero");

        step(1'b1, 4'd9, 8'h42, 1'b0, 4'd1, 4'd2, 1'b1, 8'h00, 8'h00, "post_write");
        step(1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 4'd9, 1'b1, 8'h42, 8'h42, "post_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
